// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the vending machine front end
package vm_pkg;

  // 10 ms of steady input at 100 MHz before a button or switch change is accepted
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Per-button debounce state
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  // b_in (4 bits) and sel (2 bits) are filtered as one word
  localparam int SW_W = 6;

endpackage

// File: rtl/vm_button_debounce.sv
// rtl/vm_button_debounce.sv - synchronizer, debounce FSM and press detect for one button
module vm_button_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_fire
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer; everything downstream looks only at r_s2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Press/release debounce: a level must hold for DEBOUNCE_CYCLES samples to be accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!r_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!r_s2) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (r_s2) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // High in the cycle whose closing edge moves PRESS_WAIT to HELD; the top registers it
  assign o_fire = (r_state == PRESS_WAIT) && r_s2 && (r_cnt == CNT_LAST);

endmodule

// File: rtl/vm_input_conditioner.sv
// rtl/vm_input_conditioner.sv - button press pulses and filtered switches for the main controller
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_raw,
  input  logic       load_raw,
  input  logic [3:0] b_in_raw,
  input  logic [1:0] sel_raw,
  output logic       buy_p,
  output logic       load_p,
  output logic [3:0] b_in_q,
  output logic [1:0] sel_q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // The candidate is first seen on the edge that restarts the counter, so the
  // DEBOUNCE_CYCLES-th consecutive observation happens with the counter at D-2
  localparam logic [CW-1:0] SW_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic            w_buy_fire;
  logic            w_load_fire;
  logic            r_buy_p;
  logic            r_load_p;
  logic [SW_W-1:0] r_sw_s1;
  logic [SW_W-1:0] r_sw_s2;
  logic [SW_W-1:0] r_sw_cand;
  logic [SW_W-1:0] r_sw_q;
  logic [CW-1:0]   r_sw_cnt;

  vm_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_buy (
    .clk   (clk),
    .rst   (rst),
    .i_raw (buy_raw),
    .o_fire(w_buy_fire)
  );

  vm_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load (
    .clk   (clk),
    .rst   (rst),
    .i_raw (load_raw),
    .o_fire(w_load_fire)
  );

  // Registered pulses; load wins a same-cycle tie and the buy press is simply dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buy_p  <= 1'b0;
      r_load_p <= 1'b0;
    end else begin
      r_load_p <= w_load_fire;
      r_buy_p  <= w_buy_fire & ~w_load_fire;
    end
  end

  // Switch word synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= {b_in_raw, sel_raw};
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Stability filter: any change restarts the count, a steady differing word is adopted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_cand <= '0;
      r_sw_q    <= '0;
      r_sw_cnt  <= '0;
    end else begin
      if (r_sw_s2 != r_sw_cand) begin
        r_sw_cand <= r_sw_s2;
        r_sw_cnt  <= '0;
      end else if (r_sw_cand != r_sw_q) begin
        if (r_sw_cnt == SW_LAST) begin
          r_sw_q   <= r_sw_cand;
          r_sw_cnt <= '0;
        end else begin
          r_sw_cnt <= r_sw_cnt + CNT_ONE;
        end
      end else begin
        r_sw_cnt <= '0;
      end
    end
  end

  assign buy_p  = r_buy_p;
  assign load_p = r_load_p;
  assign b_in_q = r_sw_q[5:2];
  assign sel_q  = r_sw_q[1:0];

endmodule

// File: tb/tb_vm_input_conditioner.sv
// tb/tb_vm_input_conditioner.sv - directed self-checking bench for vm_input_conditioner
module tb_vm_input_conditioner;

  localparam int D = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       buy_raw  = 1'b0;
  logic       load_raw = 1'b0;
  logic [3:0] b_in_raw = 4'd0;
  logic [1:0] sel_raw  = 2'd0;
  logic       buy_p;
  logic       load_p;
  logic [3:0] b_in_q;
  logic [1:0] sel_q;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc;
  int buy_cnt;
  int load_cnt;
  int buy_first;
  int load_first;
  int load_last;
  int nine_first;
  int saw_one;

  logic bounce [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  vm_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .buy_raw (buy_raw),
    .load_raw(load_raw),
    .b_in_raw(b_in_raw),
    .sel_raw (sel_raw),
    .buy_p   (buy_p),
    .load_p  (load_p),
    .b_in_q  (b_in_q),
    .sel_q   (sel_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    cyc        = 0;
    buy_cnt    = 0;
    load_cnt   = 0;
    buy_first  = -1;
    load_first = -1;
    load_last  = -1;
    nine_first = -1;
    saw_one    = 0;
  endtask

  // Edge k after clear_stats() samples inputs driven before it; outputs observed 1 ns later
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (buy_p) begin
        buy_cnt++;
        if (buy_first < 0) buy_first = cyc;
      end
      if (load_p) begin
        load_cnt++;
        if (load_first < 0) load_first = cyc;
        load_last = cyc;
      end
      if (b_in_q == 4'd1) saw_one = 1;
      if (b_in_q == 4'd9 && nine_first < 0) nine_first = cyc;
    end
  endtask

  initial begin
    clear_stats();

    // Reset held with every raw input high
    rst      = 1'b0;
    buy_raw  = 1'b1;
    load_raw = 1'b1;
    b_in_raw = 4'hF;
    sel_raw  = 2'd3;
    step(3);
    check("rst_buy_p", buy_p, 0);
    check("rst_load_p", load_p, 0);
    check("rst_b_in_q", b_in_q, 0);
    check("rst_sel_q", sel_q, 0);
    load_raw = 1'b0;
    b_in_raw = 4'd0;
    sel_raw  = 2'd0;
    step(1);

    // Release with buy still held: pulse after edge 1+D+1
    rst = 1'b1;
    clear_stats();
    step(20);
    check("rel_buy_first", buy_first, 1 + D + 1);
    check("rel_buy_cnt", buy_cnt, 1);
    check("rel_load_cnt", load_cnt, 0);
    buy_raw = 1'b0;
    step(10);

    // Bounce 1,0,1,0,1 then steady: final rise sampled at edge 5
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      buy_raw = bounce[i];
      step(1);
    end
    step(20);
    check("bounce_first", buy_first, 5 + D + 1);
    check("bounce_cnt", buy_cnt, 1);
    buy_raw = 1'b0;
    step(10);

    // Long hold, full release, re-press
    clear_stats();
    load_raw = 1'b1;
    step(50);
    load_raw = 1'b0;
    step(10);
    load_raw = 1'b1;
    step(20);
    load_raw = 1'b0;
    step(10);
    check("hold_load_cnt", load_cnt, 2);
    check("hold_first", load_first, 1 + D + 1);
    check("hold_second", load_last, 61 + D + 1);
    check("hold_buy_cnt", buy_cnt, 0);

    // Two-cycle release glitch mid-hold
    clear_stats();
    load_raw = 1'b1;
    step(20);
    load_raw = 1'b0;
    step(2);
    load_raw = 1'b1;
    step(20);
    load_raw = 1'b0;
    step(10);
    check("glitch_load_cnt", load_cnt, 1);

    // Simultaneous press: load wins, buy consumed
    clear_stats();
    buy_raw  = 1'b1;
    load_raw = 1'b1;
    step(20);
    buy_raw  = 1'b0;
    load_raw = 1'b0;
    step(10);
    check("sim_load_cnt", load_cnt, 1);
    check("sim_load_first", load_first, 1 + D + 1);
    check("sim_buy_cnt", buy_cnt, 0);

    // Switch filter: 2-cycle excursion to 1, then 9 steady from edge 3
    clear_stats();
    b_in_raw = 4'd1;
    step(2);
    b_in_raw = 4'd9;
    step(15);
    check("sw_no_one", saw_one, 0);
    check("sw_nine_first", nine_first, 3 + D + 1);
    check("sw_b_in_q", b_in_q, 9);

    // sel change sampled at edge 1 appears after edge 6, not before
    clear_stats();
    sel_raw = 2'd2;
    step(5);
    check("sel_early", sel_q, 0);
    step(1);
    check("sel_on_time", sel_q, 2);
    check("sel_b_in_kept", b_in_q, 9);
    step(5);

    // Asynchronous reset during PRESS_WAIT with cnt=2
    clear_stats();
    buy_raw = 1'b1;
    step(4);
    #1;
    rst = 1'b0;
    #1;
    check("async_buy_p", buy_p, 0);
    check("async_b_in_q", b_in_q, 0);
    check("async_sel_q", sel_q, 0);
    step(2);
    rst = 1'b1;
    clear_stats();
    step(20);
    check("async_rel_first", buy_first, 1 + D + 1);
    check("async_rel_cnt", buy_cnt, 1);
    check("async_rel_b_in", b_in_q, 9);
    buy_raw = 1'b0;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
